// File: rtl/div4_pkg.sv
// rtl/div4_pkg.sv - shared types and constants for the 4-bit sequential divider
package div4_pkg;

    localparam int WIDTH      = 4;
    localparam int ITERATIONS = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/sub4_flags.sv
// rtl/sub4_flags.sv - 4-bit subtractor; carry flag reports a borrow (a < b)
module sub4_flags (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] diff_o,
    output logic       carry_o
);

    assign {carry_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/div4_seq.sv
// rtl/div4_seq.sv - 4-bit unsigned restoring divider, one quotient bit per cycle
module div4_seq
    import div4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(ITERATIONS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             q_bit;

    // Partial remainder shifted left with the next dividend bit pulled in
    assign s = {r_q, q_q[WIDTH-1]};

    sub4_flags u_sub (
        .a_i    (s[WIDTH-1:0]),
        .b_i    (d_q),
        .diff_o (diff),
        .carry_o(borrow)
    );

    assign q_bit = s[WIDTH] | ~borrow;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end else begin
                        q_d     = '1;
                        r_d     = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                r_d   = q_bit ? diff : s[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div4_seq.sv
// tb/tb_div4_seq.sv - scoreboard bench for div4_seq
module tb_div4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    div4_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", int'(quotient), int'(e.q));
                chk("remainder", int'(remainder), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
                chk("latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic edbz, input int elat);
        exp_t e;
        wait_idle();
        e.q = eq; e.r = er; e.dbz = edbz; e.acc = cyc + 1; e.lat = elat;
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;

        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5);
        // start on the DONE->IDLE edge must be ignored
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done_13_3", int'(done), 1);
        dividend = 4'd2;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("ignore_at_return_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("hold_quotient", int'(quotient), 4);
        chk("hold_remainder", int'(remainder), 1);

        issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
        issue(4'd14, 4'd15, 4'd0, 4'd14, 1'b0, 5);
        issue(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1);

        issue(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 5);
        dividend = 4'd15;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;

        // Abort 9/2 during its second CALC cycle
        wait_idle();
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    issue(4'(a), 4'(b), 4'hF, 4'(a), 1'b1, 1);
                else
                    issue(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 5);
            end
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
